// File: rtl/button_debounce.sv
// Button synchroniser/debouncer with W1C press/release event registers and a level interrupt.
// Define BUTTON_RELEASE_EN to implement the RELEASE register and release events.
module button_debounce #(
    parameter int BUTTONCOUNT     = 4,
    parameter int DEBOUNCE_CYCLES = 36000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    output logic [BUTTONCOUNT-1:0] buttons_out,
    output logic                   event_int,
    input  logic [31:0]            address_in,
    input  logic                   sel_in,
    input  logic                   read_in,
    output logic [31:0]            read_value_out,
    input  logic [3:0]             write_mask_in,
    input  logic [31:0]            write_value_in,
    output logic                   ready_out
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_STATE   = 2'd0,
        REG_PRESS   = 2'd1,
        REG_RELEASE = 2'd2,
        REG_IRQ_EN  = 2'd3
    } reg_sel_e;

    logic [BUTTONCOUNT-1:0]         meta_q, sync_q;
    logic [BUTTONCOUNT-1:0]         stable_q, stable_d;
    logic [BUTTONCOUNT-1:0][CW-1:0] cnt_q, cnt_d;
    logic [BUTTONCOUNT-1:0]         accept, rise;
    logic [BUTTONCOUNT-1:0]         press_q, press_d, press_clr;
    logic [BUTTONCOUNT-1:0]         irq_en_q, irq_en_d;
    logic [BUTTONCOUNT-1:0]         release_bits;
    logic [31:0]                    lane_bits, wr_bits;
    logic                           wr_en;
    reg_sel_e                       reg_sel;
    logic                           unused_ok;

    assign reg_sel   = reg_sel_e'(address_in[3:2]);
    assign wr_en     = sel_in && (|write_mask_in);
    assign lane_bits = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                        {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    assign wr_bits   = write_value_in & lane_bits;
    assign ready_out = sel_in;
    assign unused_ok = ^{read_in, address_in, write_value_in, write_mask_in};

    // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = '0;
        for (int i = 0; i < BUTTONCOUNT; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise = accept & sync_q;

    // A debounced edge and a W1C landing on the same bit keep the bit set.
    always_comb begin
        press_clr = '0;
        irq_en_d  = irq_en_q;
        if (wr_en && reg_sel == REG_PRESS) begin
            press_clr = wr_bits[BUTTONCOUNT-1:0];
        end
        if (wr_en && reg_sel == REG_IRQ_EN) begin
            irq_en_d = (irq_en_q & ~lane_bits[BUTTONCOUNT-1:0]) | wr_bits[BUTTONCOUNT-1:0];
        end
        press_d = (press_q & ~press_clr) | rise;
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears the
    // per-button counters too, so a count in progress is abandoned on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            press_q  <= '0;
            irq_en_q <= '0;
        end else begin
            meta_q   <= buttons_in;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            irq_en_q <= irq_en_d;
        end
    end

`ifdef BUTTON_RELEASE_EN
    logic [BUTTONCOUNT-1:0] release_q, release_d, release_clr, fall;

    assign fall = accept & ~sync_q;

    always_comb begin
        release_clr = '0;
        if (wr_en && reg_sel == REG_RELEASE) begin
            release_clr = wr_bits[BUTTONCOUNT-1:0];
        end
        release_d = (release_q & ~release_clr) | fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    assign release_bits = release_q;
`else
    assign release_bits = '0;
`endif

    assign buttons_out = stable_q;
    assign event_int   = |((press_q | release_bits) & irq_en_q);

    // Zero when deselected so several slots can be OR-combined on the bus.
    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (reg_sel)
                REG_STATE:   read_value_out = 32'(stable_q);
                REG_PRESS:   read_value_out = 32'(press_q);
                REG_RELEASE: read_value_out = 32'(release_bits);
                REG_IRQ_EN:  read_value_out = 32'(irq_en_q);
                default:     read_value_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (BUTTONCOUNT=4, DEBOUNCE_CYCLES=4).
// Release expectations follow whether BUTTON_RELEASE_EN is defined for the build.
module tb_button_debounce;

`ifdef BUTTON_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  buttons_in;
    logic [3:0]  buttons_out;
    logic        event_int;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .BUTTONCOUNT     (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .buttons_in     (buttons_in),
        .buttons_out    (buttons_out),
        .event_int      (event_int),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        address_in     = addr;
        write_value_in = data;
        write_mask_in  = mask;
        sel_in         = 1'b1;
        tick();
        sel_in         = 1'b0;
        write_mask_in  = 4'b0000;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        address_in = addr;
        sel_in     = 1'b1;
        read_in    = 1'b1;
        #1;
        check(tag, read_value_out, exp);
        sel_in     = 1'b0;
        read_in    = 1'b0;
    endtask

    initial begin
        logic [6:0] glitch_pat;

        reset_n        = 1'b0;
        buttons_in     = 4'b0101;
        address_in     = '0;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        write_mask_in  = '0;
        write_value_in = '0;

        // Reset state with buttons held
        tick();
        tick();
        check("rst_out", 32'(buttons_out), 32'h0);
        check("rst_int", 32'(event_int), 32'h0);
        check("rst_rd_idle", read_value_out, 32'h0);
        check("rst_rdy_idle", 32'(ready_out), 32'h0);
        sel_in = 1'b1;
        #1;
        check("rst_rdy_sel", 32'(ready_out), 32'h1);
        check("rst_state_rd", read_value_out, 32'h0);
        sel_in = 1'b0;

        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("held_out_e%0d", e), 32'(buttons_out), (e < 6) ? 32'h0 : 32'h5);
        end
        read_check("held_press", 32'h4, 32'h5);
        read_check("held_release", 32'h8, 32'h0);
        check("held_int", 32'(event_int), 32'h0);

        // Glitch rejection on button 1: 3 high, 1 low, 3 high, then low
        glitch_pat = 7'b1110111;
        for (int k = 0; k < 13; k++) begin
            buttons_in[1] = (k < 7) ? glitch_pat[6-k] : 1'b0;
            tick();
            check($sformatf("glitch_out_%0d", k), 32'(buttons_out), 32'h5);
        end
        read_check("glitch_press", 32'h4, 32'h5);

        // Interrupt on press of button 1
        bus_write(32'hC, 32'h2, 4'b0001);
        read_check("irq_en_rd", 32'hC, 32'h2);
        buttons_in[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) begin
                check("p1_int_e5", 32'(event_int), 32'h0);
                read_check("p1_press_e5", 32'h4, 32'h5);
            end
        end
        check("p1_int_e6", 32'(event_int), 32'h1);
        read_check("p1_press_e6", 32'h4, 32'h7);
        read_check("p1_state", 32'h0, 32'h7);

        bus_write(32'h4, 32'h2, 4'b0001);
        check("w1c_int", 32'(event_int), 32'h0);
        read_check("w1c_press", 32'h4, 32'h5);
        bus_write(32'h4, 32'hF, 4'b0000);
        read_check("nomask_press", 32'h4, 32'h5);
        bus_write(32'hC, 32'h0, 4'b0000);
        read_check("nomask_irq", 32'hC, 32'h2);
        bus_write(32'h4, 32'h0000_0001, 4'b0010);
        read_check("lane_press", 32'h4, 32'h5);
        bus_write(32'h0, 32'hF, 4'b1111);
        read_check("state_ro", 32'h0, 32'h7);

        // Release of button 1
        buttons_in[1] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) read_check("r1_release_e5", 32'h8, 32'h0);
        end
        check("r1_out", 32'(buttons_out), 32'h5);
        check("r1_int", 32'(event_int), REL ? 32'h1 : 32'h0);
        address_in = 32'h8;
        sel_in     = 1'b1;
        #1;
        check("r1_release_rd", read_value_out, REL ? 32'h2 : 32'h0);
        check("r1_ready", 32'(ready_out), 32'h1);
        sel_in = 1'b0;
        #1;
        check("r1_desel_rd", read_value_out, 32'h0);
        check("r1_desel_rdy", 32'(ready_out), 32'h0);
        bus_write(32'h8, 32'hF, 4'b0001);
        check("r1_clr_int", 32'(event_int), 32'h0);

        // W1C colliding with a debounced press of button 2
        buttons_in[2] = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("r2_out", 32'(buttons_out), 32'h1);
        bus_write(32'h4, 32'h4, 4'b0001);
        bus_write(32'h8, 32'hF, 4'b0001);
        read_check("r2_press_clr", 32'h4, 32'h1);
        buttons_in[2] = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        check("coll_out_e5", 32'(buttons_out), 32'h1);
        address_in     = 32'h4;
        write_value_in = 32'h4;
        write_mask_in  = 4'b0001;
        sel_in         = 1'b1;
        tick();
        sel_in         = 1'b0;
        write_mask_in  = 4'b0000;
        check("coll_out_e6", 32'(buttons_out), 32'h5);
        read_check("coll_press", 32'h4, 32'h5);
        bus_write(32'h4, 32'h4, 4'b0001);
        read_check("coll_clr", 32'h4, 32'h1);

        // Buttons 1 and 3 pressed together
        bus_write(32'h4, 32'hF, 4'b0001);
        buttons_in = 4'b1111;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) read_check("dual_press_e5", 32'h4, 32'h0);
        end
        read_check("dual_press_e6", 32'h4, 32'hA);
        check("dual_out", 32'(buttons_out), 32'hF);

        // Button 0 release then press with only its interrupt enabled
        bus_write(32'hC, 32'h1, 4'b0001);
        bus_write(32'h4, 32'hF, 4'b0001);
        bus_write(32'h8, 32'hF, 4'b0001);
        check("b0_int_idle", 32'(event_int), 32'h0);
        buttons_in[0] = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        read_check("b0_release", 32'h8, REL ? 32'h1 : 32'h0);
        read_check("b0_press_none", 32'h4, 32'h0);
        check("b0_rel_int", 32'(event_int), REL ? 32'h1 : 32'h0);
        bus_write(32'h8, 32'h1, 4'b0001);
        check("b0_rel_clr_int", 32'(event_int), 32'h0);
        buttons_in[0] = 1'b1;
        for (int e = 1; e <= 6; e++) tick();
        read_check("b0_press", 32'h4, 32'h1);
        read_check("b0_release_none", 32'h8, 32'h0);
        check("b0_press_int", 32'(event_int), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
